// File: rtl/creek_host_pkg.sv
// ---------------------------------------------------------------------------
// creek_host_pkg: register map, CTRL bit indices and resume FSM states. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package creek_host_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_LOAD_ADDR = 3'd1;
  localparam logic [2:0] REG_LOAD_DATA = 3'd2;
  localparam logic [2:0] REG_CORE      = 3'd3;
  localparam logic [2:0] REG_INSTR     = 3'd4;

  // CTRL bit indices; bit1 means "resume request" on write and "waiting" on read
  localparam int CTRL_PAUSE_N   = 0;
  localparam int CTRL_RESUME    = 1;
  localparam int CTRL_WAITING   = 1;
  localparam int CTRL_INIT_DONE = 2;
  localparam int CTRL_LOAD_ERR  = 3;
  localparam int CTRL_PENDING   = 4;

  typedef enum logic [0:0] {
    RES_IDLE = 1'b0,
    RES_PEND = 1'b1
  } resume_state_e;

endpackage

`default_nettype wire

// File: rtl/creek_resume_ctl.sv
// ---------------------------------------------------------------------------
// creek_resume_ctl: IDLE/PEND resume handshake with single-cycle pulse. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module creek_resume_ctl
  import creek_host_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic resume_req,
  input  logic resume_cancel,
  input  logic waiting,
  output logic resume,
  output logic pending
);

  resume_state_e state_q, state_d;
  logic          resume_q, resume_d;

  always_comb begin
    state_d  = state_q;
    resume_d = 1'b0;
    case (state_q)
      RES_IDLE: begin
        // a request landing on a live pulse is absorbed, keeping pulses one cycle apart
        if (resume_req && !resume_q) begin
          if (waiting) resume_d = 1'b1;
          else         state_d  = RES_PEND;
        end
      end
      RES_PEND: begin
        if (resume_cancel) begin
          state_d = RES_IDLE;
        end else if (waiting && !resume_q) begin
          resume_d = 1'b1;
          state_d  = RES_IDLE;
        end
      end
      default: state_d = RES_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RES_IDLE;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  assign resume  = resume_q;
  assign pending = (state_q == RES_PEND);

endmodule

`default_nettype wire

// File: rtl/creek_host_bridge.sv
// ---------------------------------------------------------------------------
// creek_host_bridge: Avalon-MM register file, imem loader and core control. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module creek_host_bridge
  import creek_host_pkg::*;
#(
  parameter int IADDR_W = 10,
  parameter int IDATA_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic [IADDR_W-1:0] instr_address,
  output logic [IDATA_W-1:0] instr_writedata,
  output logic               instr_write,
  output logic               pause_n,
  output logic               resume,
  input  logic               waiting,
  input  logic               local_init_done,
  input  logic [IADDR_W-1:0] cur_pc,
  input  logic [IDATA_W-1:0] cur_instr,
  input  logic [4:0]         cur_state
);

  logic [31:0]        readdata_q, readdata_d;
  logic               rdvalid_q, rdvalid_d;
  logic [IADDR_W-1:0] iaddr_q, iaddr_d;
  logic [IDATA_W-1:0] idata_q, idata_d;
  logic               iwrite_q, iwrite_d;
  logic               pause_n_q, pause_n_d;
  logic [IADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]        load_count_q, load_count_d;
  logic               load_err_q, load_err_d;

  logic rd_en, ctrl_wr, resume_req, resume_cancel, pending;
  logic unused_ok;

  // a write wins over a simultaneous read
  assign rd_en         = avs_read && !avs_write;
  assign ctrl_wr       = avs_write && (avs_address == REG_CTRL);
  assign resume_req    = ctrl_wr && avs_writedata[CTRL_RESUME] && avs_writedata[CTRL_PAUSE_N];
  assign resume_cancel = ctrl_wr && !avs_writedata[CTRL_PAUSE_N];
  assign unused_ok     = ^avs_writedata;

  always_comb begin
    pause_n_d    = pause_n_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    iaddr_d      = iaddr_q;
    idata_d      = idata_q;
    iwrite_d     = 1'b0;
    if (avs_write) begin
      case (avs_address)
        REG_CTRL: begin
          pause_n_d = avs_writedata[CTRL_PAUSE_N];
          if (avs_writedata[CTRL_LOAD_ERR]) load_err_d = 1'b0;
        end
        REG_LOAD_ADDR: begin
          ptr_d        = avs_writedata[IADDR_W-1:0];
          load_count_d = 16'd0;
        end
        REG_LOAD_DATA: begin
          // loading is only legal while the core is held
          if (!pause_n_q) begin
            iaddr_d  = ptr_q;
            idata_d  = avs_writedata[IDATA_W-1:0];
            iwrite_d = 1'b1;
            ptr_d    = ptr_q + IADDR_W'(1);
            if (load_count_q != 16'hFFFF) load_count_d = load_count_q + 16'd1;
          end else begin
            load_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    rdvalid_d  = rd_en;
    if (rd_en) begin
      readdata_d = 32'd0;
      case (avs_address)
        REG_CTRL: begin
          readdata_d[CTRL_PAUSE_N]   = pause_n_q;
          readdata_d[CTRL_WAITING]   = waiting;
          readdata_d[CTRL_INIT_DONE] = local_init_done;
          readdata_d[CTRL_LOAD_ERR]  = load_err_q;
          readdata_d[CTRL_PENDING]   = pending;
        end
        REG_LOAD_ADDR: readdata_d[IADDR_W-1:0] = ptr_q;
        REG_LOAD_DATA: readdata_d[15:0]        = load_count_q;
        REG_CORE: begin
          readdata_d[IADDR_W-1:0] = cur_pc;
          readdata_d[20:16]       = cur_state;
        end
        REG_INSTR:     readdata_d[IDATA_W-1:0] = cur_instr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q   <= 32'd0;
      rdvalid_q    <= 1'b0;
      iaddr_q      <= '0;
      idata_q      <= '0;
      iwrite_q     <= 1'b0;
      pause_n_q    <= 1'b0;
      ptr_q        <= '0;
      load_count_q <= 16'd0;
      load_err_q   <= 1'b0;
    end else begin
      readdata_q   <= readdata_d;
      rdvalid_q    <= rdvalid_d;
      iaddr_q      <= iaddr_d;
      idata_q      <= idata_d;
      iwrite_q     <= iwrite_d;
      pause_n_q    <= pause_n_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
    end
  end

  creek_resume_ctl u_resume_ctl (
    .clk           (clk),
    .reset_n       (reset_n),
    .resume_req    (resume_req),
    .resume_cancel (resume_cancel),
    .waiting       (waiting),
    .resume        (resume),
    .pending       (pending)
  );

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = rdvalid_q;
  assign instr_address     = iaddr_q;
  assign instr_writedata   = idata_q;
  assign instr_write       = iwrite_q;
  assign pause_n           = pause_n_q;

endmodule

`default_nettype wire
